// File: rtl/disaster_alert_scheduler.sv
// Alarm persistence filter, pending latch and round-robin siren scheduler
// that sits behind the combinational disaster detector.
module disaster_alert_scheduler #(
  parameter int unsigned PERSIST   = 3,
  parameter int unsigned ON_TICKS  = 4,
  parameter int unsigned OFF_TICKS = 2,
  parameter int unsigned CNT_W     = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       flood_req,
  input  logic       cyclone_req,
  input  logic       earthquake_req,
  input  logic       tsunami_req,
  input  logic       ack,
  output logic       siren,
  output logic       alert_valid,
  output logic [1:0] alert_code,
  output logic [3:0] pending
);

  typedef enum logic [1:0] {IDLE, ANNOUNCE, GAP} state_t;

  localparam logic [CNT_W-1:0] PERSIST_C = CNT_W'(PERSIST);
  localparam logic [CNT_W-1:0] ON_C      = CNT_W'(ON_TICKS);
  localparam logic [CNT_W-1:0] OFF_C     = CNT_W'(OFF_TICKS);

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];
  logic [3:0]       pend_q, pend_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [1:0]       cur_q, cur_d;
  logic [1:0]       last_q, last_d;
  logic [3:0]       req;
  logic             grant_found;
  logic [1:0]       grant_idx;

  assign req = {tsunami_req, earthquake_req, cyclone_req, flood_req};

  // Round-robin search starting just after the last served source.
  always_comb begin
    grant_found = 1'b0;
    grant_idx   = last_q;
    for (int k = 1; k <= 4; k++) begin
      if (!grant_found && pend_q[last_q + 2'(k)]) begin
        grant_found = 1'b1;
        grant_idx   = last_q + 2'(k);
      end
    end
  end

  // NOTE: every variable gets its default first so no path through the
  // case/if tree leaves one unassigned, which would infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    timer_d = timer_q;
    cur_d   = cur_q;
    last_d  = last_q;

    if (tick) begin
      for (int i = 0; i < 4; i++) begin
        if (req[i]) begin
          if (cnt_q[i] < PERSIST_C) cnt_d[i] = cnt_q[i] + 1'b1;
          if (cnt_d[i] == PERSIST_C) pend_d[i] = 1'b1;
        end else begin
          cnt_d[i] = '0;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (grant_found) begin
          cur_d   = grant_idx;
          last_d  = grant_idx;
          timer_d = ON_C;
          state_d = ANNOUNCE;
        end
      end
      ANNOUNCE: begin
        // The acknowledge is applied after the filter so it wins over a
        // same-cycle qualification of the announced source.
        if (ack) begin
          pend_d[cur_q] = 1'b0;
          cnt_d[cur_q]  = '0;
          timer_d       = OFF_C;
          state_d       = GAP;
        end else if (tick) begin
          if (timer_q == CNT_W'(1)) begin
            timer_d = OFF_C;
            state_d = GAP;
          end else begin
            timer_d = timer_q - 1'b1;
          end
        end
      end
      GAP: begin
        if (tick) begin
          if (timer_q == CNT_W'(1)) state_d = IDLE;
          else                      timer_d = timer_q - 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      pend_q  <= '0;
      timer_q <= '0;
      cur_q   <= 2'd0;
      last_q  <= 2'd3;
      // NOTE: the small filter counter array is reset because a stale
      // count would let a source qualify early after reset.
      for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      timer_q <= timer_d;
      cur_q   <= cur_d;
      last_q  <= last_d;
      for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
    end
  end

  assign siren       = (state_q == ANNOUNCE);
  assign alert_valid = siren;
  assign alert_code  = cur_q;
  assign pending     = pend_q;

endmodule

// File: tb/tb_disaster_alert_scheduler.sv
// Bench for disaster_alert_scheduler: directed scenarios with literal
// expectations plus a randomized run checked every cycle against a model.
module tb_disaster_alert_scheduler;

  localparam int P   = 3;
  localparam int ON  = 4;
  localparam int OFF = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       tick = 1'b0;
  logic       flood_req = 1'b0, cyclone_req = 1'b0;
  logic       earthquake_req = 1'b0, tsunami_req = 1'b0;
  logic       ack = 1'b0;
  logic       siren, alert_valid;
  logic [1:0] alert_code;
  logic [3:0] pending;

  int n_checks = 0;
  int n_errors = 0;
  bit chk_en   = 1'b0;

  disaster_alert_scheduler #(
    .PERSIST(P), .ON_TICKS(ON), .OFF_TICKS(OFF), .CNT_W(8)
  ) dut (
    .clk(clk), .rst_n(rst_n), .tick(tick),
    .flood_req(flood_req), .cyclone_req(cyclone_req),
    .earthquake_req(earthquake_req), .tsunami_req(tsunami_req),
    .ack(ack), .siren(siren), .alert_valid(alert_valid),
    .alert_code(alert_code), .pending(pending)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_checks++;
    if (act !== exp_v) begin
      n_errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp_v);
    end
  endtask

  // Model: plain per-source counts, a pending set, and the announcer as
  // a mode (0 idle, 1 announcing, 2 silent gap) with ticks remaining.
  int         m_cnt [4];
  logic [3:0] m_pend;
  int         m_mode, m_rem, m_cur, m_last;

  always @(posedge clk or negedge rst_n) begin : model
    int         c [4];
    logic [3:0] p, r;
    int         mode, rem, cur, last;
    if (!rst_n) begin
      for (int i = 0; i < 4; i++) m_cnt[i] <= 0;
      m_pend <= 4'b0;
      m_mode <= 0;
      m_rem  <= 0;
      m_cur  <= 0;
      m_last <= 3;
    end else begin
      c = m_cnt; p = m_pend; mode = m_mode; rem = m_rem; cur = m_cur; last = m_last;
      r = {tsunami_req, earthquake_req, cyclone_req, flood_req};
      if (tick) begin
        for (int i = 0; i < 4; i++) begin
          if (r[i]) begin
            c[i] = (c[i] + 1 > P) ? P : c[i] + 1;
            if (c[i] == P) p[i] = 1'b1;
          end else c[i] = 0;
        end
      end
      if (m_mode == 0) begin
        for (int k = 1; k <= 4; k++) begin
          if (mode == 0 && m_pend[(m_last + k) % 4]) begin
            cur = (m_last + k) % 4; last = cur; rem = ON; mode = 1;
          end
        end
      end else if (m_mode == 1) begin
        if (ack) begin
          p[m_cur] = 1'b0; c[m_cur] = 0; mode = 2; rem = OFF;
        end else if (tick) begin
          rem = rem - 1;
          if (rem == 0) begin mode = 2; rem = OFF; end
        end
      end else if (tick) begin
        rem = rem - 1;
        if (rem == 0) mode = 0;
      end
      m_cnt <= c; m_pend <= p; m_mode <= mode; m_rem <= rem; m_cur <= cur; m_last <= last;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("siren",       32'(siren),       32'(m_mode == 1));
      check("alert_valid", 32'(alert_valid), 32'(m_mode == 1));
      check("alert_code",  32'(alert_code),  32'(m_cur));
      check("pending",     32'(pending),     32'(m_pend));
    end
  end

  task automatic step(input logic t, input logic a);
    tick = t; ack = a;
    @(posedge clk); #1;
    tick = 1'b0; ack = 1'b0;
  endtask

  task automatic steps(input int n, input logic t);
    repeat (n) step(t, 1'b0);
  endtask

  initial begin
    #2;
    check("rst_siren",   32'(siren),       32'd0);
    check("rst_valid",   32'(alert_valid), 32'd0);
    check("rst_code",    32'(alert_code),  32'd0);
    check("rst_pending", 32'(pending),     32'd0);
    #20 rst_n = 1'b1;
    chk_en = 1'b1;
    @(posedge clk); #1;

    // Flood qualification, timed ON/GAP phases, re-announcement.
    flood_req = 1'b1;
    steps(2, 1'b1);
    check("flood_not_yet", 32'(pending), 32'h0);
    step(1'b1, 1'b0);
    check("flood_pending", 32'(pending), 32'h1);
    check("siren_wait",    32'(siren),   32'd0);
    step(1'b0, 1'b0);
    check("siren_on",      32'(siren),      32'd1);
    check("code_flood",    32'(alert_code), 32'd0);
    steps(3, 1'b1);
    check("siren_3ticks",  32'(siren), 32'd1);
    step(1'b1, 1'b0);
    check("siren_off_4",   32'(siren),   32'd0);
    check("pending_kept",  32'(pending), 32'h1);
    step(1'b1, 1'b0);
    step(1'b0, 1'b1);
    check("ack_in_gap",    32'(pending), 32'h1);
    step(1'b1, 1'b0);
    check("gap_done",      32'(siren), 32'd0);
    step(1'b0, 1'b0);
    check("reannounce",    32'(siren), 32'd1);

    // Tsunami qualifies during the announcement; ack on the last tick.
    flood_req = 1'b0; tsunami_req = 1'b1;
    steps(3, 1'b1);
    check("pend_1001",     32'(pending), 32'h9);
    check("no_preempt",    32'(alert_code), 32'd0);
    step(1'b1, 1'b1);
    check("ack_tick_last", 32'(pending), 32'h8);
    check("ack_siren_off", 32'(siren),   32'd0);
    tsunami_req = 1'b0;
    steps(2, 1'b1);
    step(1'b0, 1'b0);
    check("code_tsunami",  32'(alert_code), 32'd3);
    step(1'b0, 1'b1);
    check("ack_clear",     32'(pending), 32'h0);
    check("ack_off_next",  32'(siren),   32'd0);
    step(1'b0, 1'b1);
    check("ack_gap_noop",  32'(pending), 32'h0);

    // Four pending alarms, rotate to code 1, then reset mid-announcement.
    {tsunami_req, earthquake_req, cyclone_req, flood_req} = 4'hF;
    steps(3, 1'b1);
    steps(2, 1'b0);
    check("pend_1111",     32'(pending), 32'hF);
    steps(6, 1'b1);
    step(1'b0, 1'b0);
    check("rotate_code1",  32'(alert_code), 32'd1);
    check("rotate_siren",  32'(siren),      32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("async_siren",   32'(siren),   32'd0);
    check("async_pending", 32'(pending), 32'h0);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    steps(3, 1'b1);
    check("requal_1111",   32'(pending), 32'hF);
    step(1'b0, 1'b0);
    check("first_grant0",  32'(alert_code), 32'd0);
    check("first_siren",   32'(siren),      32'd1);

    // Randomized traffic; the negedge compare checks every cycle.
    repeat (4000) begin
      if ($urandom_range(0, 7) == 0) begin
        flood_req      = ($urandom_range(0, 9) < 6);
        cyclone_req    = ($urandom_range(0, 9) < 6);
        earthquake_req = ($urandom_range(0, 9) < 6);
        tsunami_req    = ($urandom_range(0, 9) < 6);
      end
      step($urandom_range(0, 2) == 0, $urandom_range(0, 9) == 0);
    end

    chk_en = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
